// File: rtl/apb3_pkg.sv
// Shared types and constants for the APB3 master and its helpers.
package apb3_pkg;

    localparam int APB_DATA_W = 32;
    localparam int APB_STRB_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_RESP
    } apb3_state_e;

endpackage

// File: rtl/apb3_wait_timer.sv
// Counts ACCESS wait states and flags the cycle on which the timeout limit is reached.
// The counter saturates at all-ones so a long stall can never wrap back under the limit.
module apb3_wait_timer #(
    parameter  int LIMIT = 256,
    localparam int CNT_W = $clog2(LIMIT) + 1
) (
    input  logic PCLK,
    input  logic PRESET,
    input  logic clear,
    input  logic enable,
    output logic limit_hit
);

    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] LIMIT_LAST = (LIMIT == 0) ? '0 : CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] count;

    // Wait-state counter: clear wins over increment, increment stops at saturation.
    always_ff @(posedge PCLK) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (PRESET) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != CNT_MAX)) begin
            count <= count + 1'b1;
        end
    end

    // A limit of zero disables the timeout entirely.
    assign limit_hit = (LIMIT != 0) && (count == LIMIT_LAST);

endmodule

// File: rtl/apb3_master.sv
// APB3 bus master: takes one request at a time, runs a SETUP/ACCESS transfer,
// and returns a response that is held until the requester accepts it.
module apb3_master
    import apb3_pkg::*;
#(
    parameter int ADDR_W         = 12,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  PCLK,
    input  logic                  PRESET,

    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic                  req_write,
    input  logic [APB_DATA_W-1:0] req_wdata,
    input  logic [APB_STRB_W-1:0] req_strb,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [APB_DATA_W-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,

    output logic [ADDR_W-1:0]     PADDR,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [APB_DATA_W-1:0] PWDATA,
    output logic [APB_STRB_W-1:0] PSTRB,
    input  logic [APB_DATA_W-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    apb3_state_e           state, state_d;
    logic                  psel_d, penable_d, pwrite_d;
    logic [ADDR_W-1:0]     paddr_d;
    logic [APB_DATA_W-1:0] pwdata_d, rsp_rdata_d;
    logic [APB_STRB_W-1:0] pstrb_d;
    logic                  rsp_valid_d, rsp_err_d, rsp_timeout_d;
    logic                  timeout_hit;

    // The wait counter restarts on the SETUP->ACCESS edge and counts stalled ACCESS cycles.
    apb3_wait_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .clear     (state == ST_SETUP),
        .enable    ((state == ST_ACCESS) && !PREADY),
        .limit_hit (timeout_hit)
    );

    // Only the idle state takes new work; this is the one output allowed to be decoded from state.
    assign req_ready = (state == ST_IDLE);

    // Next-state and next-output decode; every register holds its value unless a transition changes it.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d       = state;
        psel_d        = PSEL;
        penable_d     = PENABLE;
        paddr_d       = PADDR;
        pwrite_d      = PWRITE;
        pwdata_d      = PWDATA;
        pstrb_d       = PSTRB;
        rsp_valid_d   = rsp_valid;
        rsp_rdata_d   = rsp_rdata;
        rsp_err_d     = rsp_err;
        rsp_timeout_d = rsp_timeout;

        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    if (req_addr[1:0] == 2'b00) begin
                        state_d   = ST_SETUP;
                        psel_d    = 1'b1;
                        penable_d = 1'b0;
                        paddr_d   = req_addr;
                        pwrite_d  = req_write;
                        pwdata_d  = req_write ? req_wdata : '0;
                        pstrb_d   = req_write ? req_strb  : '0;
                    end else begin
                        // Misaligned: answer with an error without touching the bus.
                        state_d       = ST_RESP;
                        rsp_valid_d   = 1'b1;
                        rsp_rdata_d   = '0;
                        rsp_err_d     = 1'b1;
                        rsp_timeout_d = 1'b0;
                    end
                end
            end

            ST_SETUP: begin
                state_d   = ST_ACCESS;
                penable_d = 1'b1;
            end

            ST_ACCESS: begin
                // PREADY is checked first so a completion on the limit cycle is not reported as a timeout.
                if (PREADY) begin
                    state_d       = ST_RESP;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = PWRITE ? '0 : PRDATA;
                    rsp_err_d     = PSLVERR;
                    rsp_timeout_d = 1'b0;
                end else if (timeout_hit) begin
                    state_d       = ST_RESP;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = '0;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                end
            end

            ST_RESP: begin
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any in-flight transfer or pending response.
    always_ff @(posedge PCLK) begin
        // NOTE: every register here has a reset value because all of them are visible on ports.
        if (PRESET) begin
            state       <= ST_IDLE;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            PADDR       <= '0;
            PWRITE      <= 1'b0;
            PWDATA      <= '0;
            PSTRB       <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            state       <= state_d;
            PSEL        <= psel_d;
            PENABLE     <= penable_d;
            PADDR       <= paddr_d;
            PWRITE      <= pwrite_d;
            PWDATA      <= pwdata_d;
            PSTRB       <= pstrb_d;
            rsp_valid   <= rsp_valid_d;
            rsp_rdata   <= rsp_rdata_d;
            rsp_err     <= rsp_err_d;
            rsp_timeout <= rsp_timeout_d;
        end
    end

endmodule
